bsr_stream_fifo: RTL and testbench

- Synchronous first-word-fall-through (FWFT) FIFO that sits directly downstream of the AXI write-burst router's BSR metadata/block port.
- Absorbs 32-bit words written by the router and presents them, in order, through a valid/ready stream to the BSR DMA/decoder.
- Provides full and almost-full back-pressure to the router.
- Reports occupancy, peak occupancy and sticky overflow/underflow errors for the status registers.

---
 rtl/bsr_stream_fifo_if.sv | 40 ++++
 rtl/bsr_stream_fifo.sv | 105 ++++++++++
 tb/tb_bsr_stream_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bsr_stream_fifo_if.sv
// ============================================================================
//  Module      : bsr_stream_fifo_if
//  Description : Write strobe, FWFT read stream and status bundle of the BSR FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bsr_stream_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [LVL_W-1:0]      level;
    logic [LVL_W-1:0]      peak_level;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport slave (
        input  wr_data, wr_en, rd_ready, clr_err,
        output full, almost_full, rd_data, rd_valid,
               level, peak_level, overflow, underflow
    );

    modport master (
        output wr_data, wr_en, rd_ready, clr_err,
        input  full, almost_full, rd_data, rd_valid,
               level, peak_level, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/bsr_stream_fifo.sv
// ============================================================================
//  Module      : bsr_stream_fifo
//  Description : First-word-fall-through FIFO between the AXI burst router's
//                BSR port and the BSR DMA/decoder, with occupancy and error status.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bsr_stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bsr_stream_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] c_LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_LVL_AF   = LVL_W'(DEPTH - AF_MARGIN);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;
    logic [LVL_W-1:0]      peak_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic w_full;
    logic w_rd_valid;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status flags come only from the registered level, so neither
    // rd_ready nor wr_en reaches full/rd_valid combinationally.
    assign w_full     = (level_q == c_LVL_FULL);
    assign w_rd_valid = (level_q != '0);
    assign w_wr_acc   = bus.wr_en & ~w_full;
    assign w_rd_acc   = w_rd_valid & bus.rd_ready;
    assign level_d    = level_q + LVL_W'(w_wr_acc) - LVL_W'(w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    // A new peak or a new error event takes priority over clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (level_d > peak_q) begin
                peak_q <= level_d;
            end else if (bus.clr_err) begin
                peak_q <= '0;
            end

            if (bus.wr_en & w_full) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end

            if (bus.rd_ready & ~w_rd_valid) begin
                udf_q <= 1'b1;
            end else if (bus.clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign bus.full        = w_full;
    assign bus.almost_full = (level_q >= c_LVL_AF);
    assign bus.rd_data     = mem_q[rd_ptr_q];
    assign bus.rd_valid    = w_rd_valid;
    assign bus.level       = level_q;
    assign bus.peak_level  = peak_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_bsr_stream_fifo.sv
// ============================================================================
//  Module      : tb_bsr_stream_fifo
//  Description : Self-checking bench for bsr_stream_fifo against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bsr_stream_fifo;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 16;
    localparam int c_AFM   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bsr_stream_fifo_if #(.DATA_WIDTH(c_DW), .DEPTH(c_DEPTH)) bus ();

    bsr_stream_fifo #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .AF_MARGIN  (c_AFM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: contents as a queue, level is simply its size.
    logic [c_DW-1:0] m_q[$];
    int              m_peak;
    bit              m_ovf;
    bit              m_udf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz = m_q.size();
        chk("level",       32'(bus.level),      32'(sz));
        chk("rd_valid",    32'(bus.rd_valid),   32'(sz != 0));
        chk("full",        32'(bus.full),       32'(sz == c_DEPTH));
        chk("almost_full", 32'(bus.almost_full), 32'(sz >= c_DEPTH - c_AFM));
        chk("peak_level",  32'(bus.peak_level), 32'(m_peak));
        chk("overflow",    32'(bus.overflow),   32'(m_ovf));
        chk("underflow",   32'(bus.underflow),  32'(m_udf));
        if (sz != 0) chk("rd_data", bus.rd_data, m_q[0]);
    endtask

    // One clock: drive inputs, check current outputs, advance model, take edge.
    task automatic step(input bit wen, input logic [31:0] wd, input bit rrdy,
                        input bit clr, input bit do_rst);
        bit m_full;
        bit m_empty;
        @(negedge clk);
        rst         = do_rst;
        bus.wr_en   = wen;
        bus.wr_data = wd;
        bus.rd_ready = rrdy;
        bus.clr_err = clr;
        #1;
        check_outputs();
        if (do_rst) begin
            m_q.delete();
            m_peak = 0;
            m_ovf  = 0;
            m_udf  = 0;
        end else begin
            m_full  = (m_q.size() == c_DEPTH);
            m_empty = (m_q.size() == 0);
            if (wen && m_full)          m_ovf = 1;
            else if (clr)               m_ovf = 0;
            if (rrdy && m_empty)        m_udf = 1;
            else if (clr)               m_udf = 0;
            if (rrdy && !m_empty)       void'(m_q.pop_front());
            if (wen && !m_full)         m_q.push_back(wd);
            if (m_q.size() > m_peak)    m_peak = m_q.size();
            else if (clr)               m_peak = 0;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0);
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.clr_err  = 1'b0;
        m_peak = 0;
        m_ovf  = 0;
        m_udf  = 0;

        // Power-up reset: outputs are unknown before the first edge.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Five writes with the consumer stalled.
        for (int i = 0; i < 5; i++) step(1, 32'hA0 + 32'(i), 0, 0, 0);
        idle();
        chk("t1_level", 32'(bus.level), 32'd5);
        chk("t1_head",  bus.rd_data,    32'hA0);

        // Fill to full, overflow attempt, then drain in order.
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 32'(i), 0, 0, 0);
        step(1, 32'hFF, 0, 0, 0);
        idle();
        chk("t2_level_full", 32'(bus.level), 32'd16);
        chk("t2_overflow",   32'(bus.overflow), 32'd1);
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0, 0);
        idle();

        // Full with simultaneous write and read: read wins, write dropped.
        for (int i = 0; i < 16; i++) step(1, 32'(i), 0, 0, 0);
        step(1, 32'hEE, 1, 0, 0);
        idle();
        chk("t3_level", 32'(bus.level), 32'd15);
        chk("t3_head",  bus.rd_data,    32'h01);
        for (int i = 0; i < 15; i++) step(0, '0, 1, 0, 0);

        // Clear errors while empty, then write-while-empty with rd_ready.
        step(0, '0, 0, 1, 0);
        step(1, 32'h55, 1, 0, 0);
        idle();
        chk("t4_underflow", 32'(bus.underflow), 32'd1);
        chk("t4_data",      bus.rd_data,        32'h55);
        step(0, '0, 1, 0, 0);

        // Streaming at one word per cycle across two pointer wraps.
        step(0, '0, 0, 1, 1);
        step(1, 32'd0, 0, 0, 0);
        for (int i = 1; i < 40; i++) step(1, 32'(i), 1, 0, 0);
        step(0, '0, 1, 0, 0);
        idle();
        chk("t5_peak", 32'(bus.peak_level), 32'd1);
        step(0, '0, 0, 1, 0);
        idle();
        chk("t5_peak_clr", 32'(bus.peak_level), 32'd0);

        // Mid-operation reset discards contents.
        for (int i = 0; i < 9; i++) step(1, 32'h100 + 32'(i), 0, 0, 0);
        step(0, '0, 0, 0, 1);
        idle();
        chk("t6_level", 32'(bus.level), 32'd0);
        step(1, 32'h77, 0, 0, 0);
        idle();
        chk("t6_head", bus.rd_data, 32'h77);
        step(0, '0, 1, 0, 0);

        // Randomized traffic with shifting write/read bias.
        for (int i = 0; i < 3000; i++) begin
            int  ph   = (i / 250) % 4;
            int  wpct = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            int  rpct = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 50 : 95;
            bit  wen  = ($urandom_range(99) < wpct);
            bit  rrdy = ($urandom_range(99) < rpct);
            bit  clr  = 0;
            bit  rs   = ($urandom_range(499) == 0);
            if (m_q.size() == 0 && !wen && $urandom_range(9) == 0) clr = 1;
            step(wen, $urandom, rrdy, clr, rs);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
